efi_multi_timer: RTL and testbench

EFI_MULTI_TIMER -- requirements
Module: efi_multi_timer

---
 rtl/efi_multi_timer.sv | 191 +++++++++++++++++++
 tb/tb_efi_multi_timer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/efi_multi_timer.sv
// efi_multi_timer
//   Multi-channel fuel-injector pulse timer driven by an ignition coil sense.
//   Each accepted ignition event opens the injectors (all of them in batch
//   mode, one rotating channel in sequential mode) for a per-channel length
//   counted in 1 us ticks. The coil period is measured in 20 us ticks, and a
//   stalled engine is flagged when that period exceeds a programmable limit.
//
// Ports
//   sysclk                sole clock, rising edge
//   sysreset              asynchronous active-high reset
//   pulse1m               one-cycle 1 MHz tick (injector countdown)
//   pulse50k              one-cycle 50 kHz tick (period measurement)
//   ign_coil              asynchronous ignition coil sense
//   efi_enable            master enable
//   seq_mode              0 = batch, 1 = sequential
//   ign_timeout_len_20us  stall limit in 20 us ticks
//   efi_len_us            per-channel pulse length, channel k at [k*WIDTH +: WIDTH]
//   injector_open         per-channel injector drive, 1 = open
//   puff_event            one-cycle pulse per accepted ignition event
//   ign_timeout           engine stalled (level)
//   ign_period_20us       last measured ignition period
//   next_channel          channel the next sequential event fires
module efi_multi_timer #(
  parameter int  CHANNELS = 4,
  parameter int  WIDTH    = 16,
  localparam int NCW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      sysclk,
  input  logic                      sysreset,
  input  logic                      pulse1m,
  input  logic                      pulse50k,
  input  logic                      ign_coil,
  input  logic                      efi_enable,
  input  logic                      seq_mode,
  input  logic [WIDTH-1:0]          ign_timeout_len_20us,
  input  logic [CHANNELS*WIDTH-1:0] efi_len_us,
  output logic [CHANNELS-1:0]       injector_open,
  output logic                      puff_event,
  output logic                      ign_timeout,
  output logic [WIDTH-1:0]          ign_period_20us,
  output logic [NCW-1:0]            next_channel
);

  typedef enum logic {ST_TIMEOUT, ST_RUN} run_state_t;
  typedef enum logic {CH_IDLE, CH_OPEN} ch_state_t;

  logic             coil_s1;
  logic             coil_s2;
  logic             coil_s3;
  logic             ign_event;
  logic [WIDTH-1:0] period_cnt;
  run_state_t       state;
  run_state_t       state_next;
  logic             accept;
  logic [CHANNELS-1:0] load;
  ch_state_t        ch_state       [CHANNELS];
  ch_state_t        ch_state_next  [CHANNELS];
  logic [WIDTH-1:0] countdown      [CHANNELS];
  logic [WIDTH-1:0] countdown_next [CHANNELS];

  // Two-flop synchroniser for the coil sense; the third flop only remembers
  // the previous synchronised level so a rising edge can be detected.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      coil_s1 <= 1'b0;
      coil_s2 <= 1'b0;
      coil_s3 <= 1'b0;
    end else begin
      coil_s1 <= ign_coil;
      coil_s2 <= coil_s1;
      coil_s3 <= coil_s2;
    end
  end

  assign ign_event = coil_s2 & ~coil_s3;

  // Period measurement: an event wins over a simultaneous 50 kHz tick, so the
  // tick in the event cycle is dropped rather than counted into the new period.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      period_cnt      <= '0;
      ign_period_20us <= '1;
    end else if (ign_event) begin
      ign_period_20us <= period_cnt;
      period_cnt      <= '0;
    end else if (pulse50k && (period_cnt != '1)) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Run/timeout state register.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state <= ST_TIMEOUT;
    end else begin
      state <= state_next;
    end
  end

  // An event in RUN takes priority over the stall test: the counter is being
  // cleared by that same event, so the engine is demonstrably still turning.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_TIMEOUT: begin
        if (ign_event) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ign_event) begin
          accept = efi_enable;
        end else if (period_cnt >= ign_timeout_len_20us) begin
          state_next = ST_TIMEOUT;
        end
      end
    endcase
  end

  assign ign_timeout = (state == ST_TIMEOUT);

  // Puff strobe and sequential rotation pointer; the pointer is held at 0 for
  // as long as the engine is considered stalled.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      puff_event   <= 1'b0;
      next_channel <= '0;
    end else begin
      puff_event <= accept;
      if (state_next == ST_TIMEOUT) begin
        next_channel <= '0;
      end else if (accept && seq_mode) begin
        next_channel <= (next_channel == NCW'(CHANNELS - 1)) ? '0 : next_channel + 1'b1;
      end
    end
  end

  always_comb begin
    load = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      load[k] = accept && (!seq_mode || (next_channel == NCW'(k)));
    end
  end

  // Per-channel countdown. A load overrides both a pending 1 MHz tick and an
  // open channel (retrigger); a zero-length load leaves the channel closed.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      ch_state_next[k]  = ch_state[k];
      countdown_next[k] = countdown[k];
      if (!efi_enable) begin
        ch_state_next[k]  = CH_IDLE;
        countdown_next[k] = '0;
      end else if (load[k]) begin
        countdown_next[k] = efi_len_us[k*WIDTH +: WIDTH];
        ch_state_next[k]  = (efi_len_us[k*WIDTH +: WIDTH] == '0) ? CH_IDLE : CH_OPEN;
      end else if (ch_state[k] == CH_OPEN) begin
        if (countdown[k] == '0) begin
          ch_state_next[k] = CH_IDLE;
        end else if (pulse1m) begin
          countdown_next[k] = countdown[k] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        ch_state[k]  <= CH_IDLE;
        countdown[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        ch_state[k]  <= ch_state_next[k];
        countdown[k] <= countdown_next[k];
      end
    end
  end

  // Injector drive comes straight from channel state so an asynchronous reset
  // closes every injector without waiting for a clock edge.
  always_comb begin
    injector_open = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      injector_open[k] = (ch_state[k] == CH_OPEN);
    end
  end

endmodule

// File: tb/tb_efi_multi_timer.sv
// tb_efi_multi_timer
//   Randomised scenarios for efi_multi_timer compared cycle by cycle against
//   an event-level reference model. Tick rates are compressed: pulse1m every
//   P1 clocks and pulse50k every P50 clocks.
module tb_efi_multi_timer;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int NCW  = 2;
  localparam int P1   = 3;
  localparam int P50  = 5;
  localparam int MAXC = (1 << W) - 1;

  logic            sysclk = 1'b0;
  logic            sysreset;
  logic            pulse1m;
  logic            pulse50k;
  logic            ign_coil;
  logic            efi_enable;
  logic            seq_mode;
  logic [W-1:0]    ign_timeout_len_20us;
  logic [CH*W-1:0] efi_len_us;
  logic [CH-1:0]   injector_open;
  logic            puff_event;
  logic            ign_timeout;
  logic [W-1:0]    ign_period_20us;
  logic [NCW-1:0]  next_channel;

  int checks   = 0;
  int failures = 0;

  efi_multi_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
    .sysclk               (sysclk),
    .sysreset             (sysreset),
    .pulse1m              (pulse1m),
    .pulse50k             (pulse50k),
    .ign_coil             (ign_coil),
    .efi_enable           (efi_enable),
    .seq_mode             (seq_mode),
    .ign_timeout_len_20us (ign_timeout_len_20us),
    .efi_len_us           (efi_len_us),
    .injector_open        (injector_open),
    .puff_event           (puff_event),
    .ign_timeout          (ign_timeout),
    .ign_period_20us      (ign_period_20us),
    .next_channel         (next_channel)
  );

  always #5 sysclk = ~sysclk;

  // Reference model. An ignition event is processed two edges after the edge
  // that first samples the coil high. A loaded channel closes one edge after
  // the len-th 1 MHz tick following the load edge, computed arithmetically
  // from the fixed tick phase.
  int            edge_idx = 0;
  logic          prev_coil;
  int            evt_q[$];
  int            m_cnt;
  logic          m_timeout;
  logic          m_puff;
  int            m_period;
  int            m_next;
  logic [CH-1:0] m_open;
  int            m_close [CH];
  logic          evt;
  logic          acc;
  logic          ld;
  int            len_k;

  always @(posedge sysclk) begin
    if (sysreset) begin
      evt_q.delete();
      prev_coil = 1'b0;
      m_cnt     = 0;
      m_timeout = 1'b1;
      m_puff    = 1'b0;
      m_period  = MAXC;
      m_next    = 0;
      m_open    = '0;
    end else begin
      evt = (evt_q.size() > 0) && (evt_q[0] == edge_idx);
      if (evt) void'(evt_q.pop_front());
      if (ign_coil && !prev_coil) evt_q.push_back(edge_idx + 2);
      prev_coil = ign_coil;
      acc = evt && !m_timeout && efi_enable;
      for (int k = 0; k < CH; k++) begin
        ld    = acc && (!seq_mode || (k == m_next));
        len_k = int'(efi_len_us[k*W +: W]);
        if (!efi_enable) begin
          m_open[k] = 1'b0;
        end else if (ld) begin
          if (len_k == 0) begin
            m_open[k] = 1'b0;
          end else begin
            m_open[k]  = 1'b1;
            m_close[k] = ((edge_idx / P1) + 1) * P1 + (len_k - 1) * P1 + 1;
          end
        end else if (m_open[k] && (edge_idx == m_close[k])) begin
          m_open[k] = 1'b0;
        end
      end
      m_puff = acc;
      if (m_timeout) begin
        if (evt) m_timeout = 1'b0;
      end else if (!evt && (m_cnt >= int'(ign_timeout_len_20us))) begin
        m_timeout = 1'b1;
      end
      if (m_timeout) m_next = 0;
      else if (acc && seq_mode) m_next = (m_next + 1) % CH;
      if (evt) begin
        m_period = m_cnt;
        m_cnt    = 0;
      end else if (pulse50k && (m_cnt < MAXC)) begin
        m_cnt = m_cnt + 1;
      end
    end
    edge_idx = edge_idx + 1;
    #1;
    pulse1m  = (edge_idx % P1 == 0);
    pulse50k = (edge_idx % P50 == 0);
  end

  // Drive the coil for the coming edge, then settle 2 time units after it.
  task automatic step(input logic coil);
    ign_coil = coil;
    @(posedge sysclk);
    #2;
  endtask

  task automatic test_reset();
    sysreset = 1'b1;
    step(1'b0);
    step(1'b0);
    checks++; if (injector_open !== 4'b0000) begin failures++; $display("[TB] FAIL reset_open got=%b exp=%b", injector_open, 4'b0000); end
    checks++; if (puff_event !== 1'b0) begin failures++; $display("[TB] FAIL reset_puff got=%b exp=0", puff_event); end
    checks++; if (ign_timeout !== 1'b1) begin failures++; $display("[TB] FAIL reset_timeout got=%b exp=1", ign_timeout); end
    checks++; if (ign_period_20us !== 8'hFF) begin failures++; $display("[TB] FAIL reset_period got=%0d exp=255", ign_period_20us); end
    checks++; if (next_channel !== 2'd0) begin failures++; $display("[TB] FAIL reset_next got=%0d exp=0", next_channel); end
    sysreset = 1'b0;
  endtask

  task automatic test_batch();
    efi_enable = 1'b1; seq_mode = 1'b0; ign_timeout_len_20us = 8'd200;
    for (int ev = 0; ev < 6; ev++) begin
      int gap;
      for (int c = 0; c < CH; c++) efi_len_us[c*W +: W] = W'($urandom_range(1, 15));
      gap = $urandom_range(60, 120);
      for (int i = 0; i < gap; i++) begin
        step(i < 3);
        checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL batch_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
        checks++; if (puff_event !== m_puff) begin failures++; $display("[TB] FAIL batch_puff edge=%0d got=%b exp=%b", edge_idx, puff_event, m_puff); end
        checks++; if (ign_period_20us !== W'(m_period)) begin failures++; $display("[TB] FAIL batch_period edge=%0d got=%0d exp=%0d", edge_idx, ign_period_20us, m_period); end
        checks++; if (ign_timeout !== m_timeout) begin failures++; $display("[TB] FAIL batch_timeout edge=%0d got=%b exp=%b", edge_idx, ign_timeout, m_timeout); end
      end
    end
  endtask

  task automatic test_sequential();
    efi_enable = 1'b1; seq_mode = 1'b1; ign_timeout_len_20us = 8'd200;
    for (int ev = 0; ev < 8; ev++) begin
      int gap;
      for (int c = 0; c < CH; c++) efi_len_us[c*W +: W] = W'($urandom_range(5, 25));
      gap = $urandom_range(30, 60);
      for (int i = 0; i < gap; i++) begin
        step(i < 3);
        checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL seq_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
        checks++; if (next_channel !== NCW'(m_next)) begin failures++; $display("[TB] FAIL seq_next edge=%0d got=%0d exp=%0d", edge_idx, next_channel, m_next); end
        checks++; if (puff_event !== m_puff) begin failures++; $display("[TB] FAIL seq_puff edge=%0d got=%b exp=%b", edge_idx, puff_event, m_puff); end
      end
    end
  endtask

  task automatic test_retrigger();
    efi_enable = 1'b1; seq_mode = 1'b0; ign_timeout_len_20us = 8'd200;
    for (int c = 0; c < CH; c++) efi_len_us[c*W +: W] = 8'd25;
    for (int ev = 0; ev < 6; ev++) begin
      int gap;
      gap = (ev == 5) ? 110 : $urandom_range(20, 40);
      for (int i = 0; i < gap; i++) begin
        step(i < 3);
        checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL retrig_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
      end
    end
  endtask

  task automatic test_enable_drop();
    efi_enable = 1'b1; seq_mode = 1'b0; ign_timeout_len_20us = 8'd200;
    for (int c = 0; c < CH; c++) efi_len_us[c*W +: W] = 8'd20;
    for (int i = 0; i < 12; i++) begin
      step(i < 3);
      checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL en_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
    end
    efi_enable = 1'b0;
    step(1'b0);
    checks++; if (injector_open !== 4'b0000) begin failures++; $display("[TB] FAIL en_drop_close got=%b exp=%b", injector_open, 4'b0000); end
    for (int ev = 0; ev < 3; ev++) begin
      for (int i = 0; i < 40; i++) begin
        step(i < 3);
        checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL en_off_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
        checks++; if (puff_event !== m_puff) begin failures++; $display("[TB] FAIL en_off_puff edge=%0d got=%b exp=%b", edge_idx, puff_event, m_puff); end
        checks++; if (ign_period_20us !== W'(m_period)) begin failures++; $display("[TB] FAIL en_off_period edge=%0d got=%0d exp=%0d", edge_idx, ign_period_20us, m_period); end
      end
    end
    efi_enable = 1'b1;
  endtask

  task automatic test_zero_len();
    efi_enable = 1'b1; ign_timeout_len_20us = 8'd200;
    for (int ev = 0; ev < 8; ev++) begin
      seq_mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) begin
        efi_len_us[c*W +: W] = ($urandom_range(0, 1) == 0) ? 8'd0 : W'($urandom_range(1, 8));
      end
      efi_len_us[(ev % CH)*W +: W] = 8'd0;
      for (int i = 0; i < 35; i++) begin
        step(i < 3);
        checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL zero_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
        checks++; if (puff_event !== m_puff) begin failures++; $display("[TB] FAIL zero_puff edge=%0d got=%b exp=%b", edge_idx, puff_event, m_puff); end
        checks++; if (next_channel !== NCW'(m_next)) begin failures++; $display("[TB] FAIL zero_next edge=%0d got=%0d exp=%0d", edge_idx, next_channel, m_next); end
      end
    end
  endtask

  task automatic test_back_to_back();
    efi_enable = 1'b1; ign_timeout_len_20us = 8'd200;
    for (int ev = 0; ev < 14; ev++) begin
      int gap;
      seq_mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) efi_len_us[c*W +: W] = W'($urandom_range(0, 20));
      gap = $urandom_range(8, 50);
      for (int i = 0; i < gap; i++) begin
        step(i < 3);
        if (i == 5) efi_len_us[0 +: W] = W'($urandom_range(0, 20));
        checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL b2b_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
        checks++; if (puff_event !== m_puff) begin failures++; $display("[TB] FAIL b2b_puff edge=%0d got=%b exp=%b", edge_idx, puff_event, m_puff); end
        checks++; if (next_channel !== NCW'(m_next)) begin failures++; $display("[TB] FAIL b2b_next edge=%0d got=%0d exp=%0d", edge_idx, next_channel, m_next); end
        checks++; if (ign_period_20us !== W'(m_period)) begin failures++; $display("[TB] FAIL b2b_period edge=%0d got=%0d exp=%0d", edge_idx, ign_period_20us, m_period); end
      end
    end
  endtask

  task automatic test_timeout();
    efi_enable = 1'b1; seq_mode = 1'b1; ign_timeout_len_20us = 8'd20;
    for (int c = 0; c < CH; c++) efi_len_us[c*W +: W] = 8'd4;
    for (int i = 0; i < 1400; i++) begin
      step(i < 3);
      checks++; if (ign_timeout !== m_timeout) begin failures++; $display("[TB] FAIL tmo_level edge=%0d got=%b exp=%b", edge_idx, ign_timeout, m_timeout); end
      checks++; if (next_channel !== NCW'(m_next)) begin failures++; $display("[TB] FAIL tmo_next edge=%0d got=%0d exp=%0d", edge_idx, next_channel, m_next); end
      checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL tmo_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
    end
    checks++; if (ign_timeout !== 1'b1) begin failures++; $display("[TB] FAIL tmo_stalled got=%b exp=1", ign_timeout); end
    for (int ev = 0; ev < 2; ev++) begin
      for (int i = 0; i < 40; i++) begin
        step(i < 3);
        checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL tmo_rec_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
        checks++; if (puff_event !== m_puff) begin failures++; $display("[TB] FAIL tmo_rec_puff edge=%0d got=%b exp=%b", edge_idx, puff_event, m_puff); end
        checks++; if (ign_timeout !== m_timeout) begin failures++; $display("[TB] FAIL tmo_rec_level edge=%0d got=%b exp=%b", edge_idx, ign_timeout, m_timeout); end
        checks++; if (ign_period_20us !== W'(m_period)) begin failures++; $display("[TB] FAIL tmo_rec_period edge=%0d got=%0d exp=%0d", edge_idx, ign_period_20us, m_period); end
      end
      if (ev == 0) begin
        checks++; if (ign_period_20us !== 8'hFF) begin failures++; $display("[TB] FAIL tmo_saturated got=%0d exp=255", ign_period_20us); end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    efi_enable = 1'b1; seq_mode = 1'b0; ign_timeout_len_20us = 8'd200;
    for (int c = 0; c < CH; c++) efi_len_us[c*W +: W] = 8'd20;
    for (int i = 0; i < 10; i++) begin
      step(i < 3);
      checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL rst_pre_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
    end
    #3 sysreset = 1'b1;
    #1;
    checks++; if (injector_open !== 4'b0000) begin failures++; $display("[TB] FAIL rst_async_open got=%b exp=%b", injector_open, 4'b0000); end
    checks++; if (ign_timeout !== 1'b1) begin failures++; $display("[TB] FAIL rst_async_timeout got=%b exp=1", ign_timeout); end
    checks++; if (ign_period_20us !== 8'hFF) begin failures++; $display("[TB] FAIL rst_async_period got=%0d exp=255", ign_period_20us); end
    step(1'b0);
    step(1'b0);
    sysreset = 1'b0;
    for (int ev = 0; ev < 2; ev++) begin
      for (int i = 0; i < 30; i++) begin
        step(i < 3);
        checks++; if (injector_open !== m_open) begin failures++; $display("[TB] FAIL rst_post_open edge=%0d got=%b exp=%b", edge_idx, injector_open, m_open); end
        checks++; if (puff_event !== m_puff) begin failures++; $display("[TB] FAIL rst_post_puff edge=%0d got=%b exp=%b", edge_idx, puff_event, m_puff); end
      end
    end
  endtask

  initial begin
    sysreset             = 1'b1;
    pulse1m              = 1'b1;
    pulse50k             = 1'b1;
    ign_coil             = 1'b0;
    efi_enable           = 1'b0;
    seq_mode             = 1'b0;
    ign_timeout_len_20us = 8'd200;
    efi_len_us           = '0;
    #2;
    test_reset();
    test_batch();
    test_sequential();
    test_retrigger();
    test_enable_drop();
    test_zero_len();
    test_back_to_back();
    test_timeout();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
